// File: rtl/dense_layer_sequencer_if.sv
// Handshake and configuration bundle between the layer sequencer and the dense core.
// The master side is the sequencer; the slave side is the core.
interface dense_layer_sequencer_if #(
   parameter int DW = 32
);
   logic          start_dat;
   logic          start_vld;
   logic          start_rdy;
   logic          done_dat;
   logic          done_vld;
   logic          done_rdy;
   logic [DW-1:0] use_relu;
   logic [DW-1:0] feature_addr;
   logic [DW-1:0] weight_addr;
   logic [DW-1:0] output_addr;
   logic [DW-1:0] in_vector_length;
   logic [DW-1:0] out_vector_length;

   modport master (
      output start_dat, start_vld, done_rdy,
      output use_relu, feature_addr, weight_addr, output_addr,
      output in_vector_length, out_vector_length,
      input  start_rdy, done_dat, done_vld
   );

   modport slave (
      input  start_dat, start_vld, done_rdy,
      input  use_relu, feature_addr, weight_addr, output_addr,
      input  in_vector_length, out_vector_length,
      output start_rdy, done_dat, done_vld
   );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Walks a descriptor table layer by layer, programming the dense core and chaining
// each layer's output into the next layer's input through two ping-pong scratch buffers.
module dense_layer_sequencer #(
   parameter int MAX_LAYERS = 8,
   parameter int LAYER_AW   = 3,
   parameter int DW         = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [LAYER_AW+1:0] cfg_addr,
   input  logic [DW-1:0]       cfg_wdata,
   input  logic                run_start,
   input  logic                abort,
   input  logic [LAYER_AW:0]   num_layers,
   input  logic [DW-1:0]       input_addr,
   input  logic [DW-1:0]       final_output_addr,
   input  logic [DW-1:0]       scratch_addr_a,
   input  logic [DW-1:0]       scratch_addr_b,
   output logic                busy,
   output logic                run_done,
   output logic                run_err,
   output logic                aborted,
   output logic [LAYER_AW:0]   current_layer,
   output logic [DW-1:0]       run_cycles,
   dense_layer_sequencer_if.master core
);
   localparam logic [LAYER_AW:0] MAX_L = (LAYER_AW+1)'(MAX_LAYERS);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_DONE, NEXT, FINISH} state_t;
   state_t state, nxt;

   logic [DW-1:0]       desc [MAX_LAYERS][4];
   logic [LAYER_AW:0]   nl_q;
   logic [DW-1:0]       in_q, fin_q, sa_q, sb_q;
   logic                pend;
   logic [DW-1:0]       cfg_relu, cfg_feat, cfg_wt, cfg_out, cfg_inl, cfg_outl;
   logic [LAYER_AW:0]   layer_inc;
   logic [LAYER_AW-1:0] cur_idx;
   logic                last, skip, unused_done_dat;

   assign layer_inc       = current_layer + 1'b1;
   assign cur_idx         = current_layer[LAYER_AW-1:0];
   assign last            = (layer_inc == nl_q);
   assign skip            = (nl_q == '0) || run_err;
   assign unused_done_dat = core.done_dat;

   assign busy     = (state == LOAD) || (state == ISSUE) || (state == WAIT_DONE) || (state == NEXT);
   assign run_done = (state == FINISH);

   assign core.start_dat         = 1'b1;
   assign core.start_vld         = (state == ISSUE);
   assign core.done_rdy          = (state == WAIT_DONE);
   assign core.use_relu          = cfg_relu;
   assign core.feature_addr      = cfg_feat;
   assign core.weight_addr       = cfg_wt;
   assign core.output_addr       = cfg_out;
   assign core.in_vector_length  = cfg_inl;
   assign core.out_vector_length = cfg_outl;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   // Empty and oversized runs pass through NEXT without touching the core, so
   // their completion pulse lands two cycles after run_start like a layer tail.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:      if (run_start) nxt = (num_layers == '0 || num_layers > MAX_L) ? NEXT : LOAD;
         LOAD:      nxt = abort ? FINISH : ISSUE;
         ISSUE:     if (core.start_rdy) nxt = WAIT_DONE;
                    else if (abort)     nxt = FINISH;
         WAIT_DONE: if (core.done_vld)  nxt = NEXT;
         NEXT:      nxt = (skip || pend || abort || last) ? FINISH : LOAD;
         FINISH:    nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // Table is deliberately left out of reset so descriptors survive a run reset.
   always_ff @(posedge clock) begin
      if (state == IDLE && cfg_we)
         desc[cfg_addr[LAYER_AW+1:2]][cfg_addr[1:0]] <= cfg_wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         nl_q          <= '0;
         in_q          <= '0;
         fin_q         <= '0;
         sa_q          <= '0;
         sb_q          <= '0;
         pend          <= 1'b0;
         run_err       <= 1'b0;
         aborted       <= 1'b0;
         current_layer <= '0;
         run_cycles    <= '0;
         cfg_relu      <= '0;
         cfg_feat      <= '0;
         cfg_wt        <= '0;
         cfg_out       <= '0;
         cfg_inl       <= '0;
         cfg_outl      <= '0;
      end else begin
         if (busy && run_cycles != '1) run_cycles <= run_cycles + 1'b1;
         unique case (state)
            IDLE: if (run_start) begin
               nl_q          <= num_layers;
               in_q          <= input_addr;
               fin_q         <= final_output_addr;
               sa_q          <= scratch_addr_a;
               sb_q          <= scratch_addr_b;
               run_err       <= (num_layers > MAX_L);
               aborted       <= 1'b0;
               pend          <= 1'b0;
               current_layer <= '0;
               run_cycles    <= '0;
            end
            LOAD: begin
               cfg_relu <= desc[cur_idx][0];
               cfg_wt   <= desc[cur_idx][1];
               cfg_inl  <= desc[cur_idx][2];
               cfg_outl <= desc[cur_idx][3];
               cfg_feat <= (current_layer == '0) ? in_q : cfg_out;
               cfg_out  <= last ? fin_q : (current_layer[0] ? sb_q : sa_q);
               if (abort) aborted <= 1'b1;
            end
            // A start handshake that coincides with abort still hands the layer to the core.
            ISSUE: if (abort) begin
               if (core.start_rdy) pend    <= 1'b1;
               else                aborted <= 1'b1;
            end
            WAIT_DONE: if (abort) pend <= 1'b1;
            NEXT: if (!skip) begin
               current_layer <= layer_inc;
               if (pend || abort) aborted <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
